newton_iter_scheduler: RTL and testbench

Sequencing controller for the Newton–Raphson inverse-square-root datapath. Accepts {x/2, y0, id} operand sets over a valid/ready handshake and issues them into the fixed-latency Newton step pipeline. Recirculates each result back through the same pipeline for ITERS refinement steps, then emits the final y with its id. The datapath carries only y, so a shadow pipeline holds x/2, the iteration count and the id alongside each in-flight item.

---
 rtl/newton_pkg.sv | 18 +
 rtl/newton_shadow_pipe.sv | 48 ++++
 rtl/newton_iter_scheduler.sv | 139 +++++++++++++
 tb/tb_newton_iter_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/newton_pkg.sv
// Shared constants and width helpers for the Newton-Raphson inverse-sqrt scheduler.
// The shadow record type depends on instance parameters, so it is declared in the
// top level using the widths these helpers return.
package newton_pkg;

  localparam int unsigned FP_W = 32;

  // Iteration counter width; at least one bit so the field always exists.
  function automatic int unsigned it_width(input int unsigned iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

  // Width able to hold 0..pipe_lat+1 items in flight.
  function automatic int unsigned inflight_width(input int unsigned pipe_lat);
    return $clog2(pipe_lat + 2);
  endfunction

endpackage

// File: rtl/newton_shadow_pipe.sv
// Delay line carrying per-item side data alongside the Newton step datapath.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low clear of every stage
//   en_i   - shared shift enable (0 holds all stages)
//   d_i    - record entering stage 1
//   q_o    - record leaving the last stage (aligned with the datapath result)
module newton_shadow_pipe #(
  parameter int unsigned Depth = 4,
  parameter type         elem_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  elem_t d_i,
  output elem_t q_o
);

  elem_t stage_d [Depth];
  elem_t stage_q [Depth];

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (en_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < Depth; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/newton_iter_scheduler.sv
// Issue/recirculate/retire controller for the fixed-latency Newton inverse-sqrt step.
// Ports:
//   clk, rst (async, active-low), en (global freeze when 0)
//   in_valid/in_ready/in_xh/in_y0/in_id - operand handshake
//   dp_ce, dp_a, dp_b (registered) -> datapath; dp_y <- datapath, PIPE_LAT cycles later
//   out_valid/out_y/out_id - one-cycle result pulse, no backpressure
//   inflight/busy - occupancy of the shadow pipeline
module newton_iter_scheduler
  import newton_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned ITERS    = 2,
  parameter int unsigned ID_W     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FP_W-1:0]                      in_xh,
  input  logic [FP_W-1:0]                      in_y0,
  input  logic [ID_W-1:0]                      in_id,
  output logic                                 dp_ce,
  output logic [FP_W-1:0]                      dp_a,
  output logic [FP_W-1:0]                      dp_b,
  input  logic [FP_W-1:0]                      dp_y,
  output logic                                 out_valid,
  output logic [FP_W-1:0]                      out_y,
  output logic [ID_W-1:0]                      out_id,
  output logic [inflight_width(PIPE_LAT)-1:0]  inflight,
  output logic                                 busy
);

  localparam int unsigned IT_W  = it_width(ITERS);
  localparam int unsigned CNT_W = inflight_width(PIPE_LAT);
  localparam logic [IT_W-1:0] LastIt = IT_W'(ITERS - 1);

  typedef struct packed {
    logic            v;
    logic [IT_W-1:0] it;
    logic [FP_W-1:0] xh;
    logic [ID_W-1:0] id;
  } shadow_t;

  shadow_t               stage0_d, stage0_q, tail;
  logic [FP_W-1:0]       dp_a_d, dp_a_q, dp_b_d, dp_b_q;
  logic                  out_valid_d, out_valid_q;
  logic [FP_W-1:0]       out_y_d, out_y_q;
  logic [ID_W-1:0]       out_id_d, out_id_q;
  logic [CNT_W-1:0]      inflight_d, inflight_q;
  logic                  recirc, retire, accept;

  // Stages 1..PIPE_LAT; stage 0 lives here because it also drives dp_a/dp_b.
  newton_shadow_pipe #(
    .Depth  (PIPE_LAT),
    .elem_t (shadow_t)
  ) u_shadow (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (en),
    .d_i    (stage0_q),
    .q_o    (tail)
  );

  always_comb begin
    recirc   = tail.v && (tail.it != LastIt);
    retire   = tail.v && (tail.it == LastIt);
    // Recirculation owns the issue slot, so input is refused on those cycles.
    in_ready = en && !recirc;
    accept   = in_valid && in_ready;

    stage0_d    = stage0_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    out_valid_d = 1'b0;
    out_y_d     = out_y_q;
    out_id_d    = out_id_q;
    inflight_d  = inflight_q;

    if (en) begin
      if (recirc) begin
        stage0_d.v  = 1'b1;
        stage0_d.it = IT_W'(tail.it + 1'b1);
        stage0_d.xh = tail.xh;
        stage0_d.id = tail.id;
        dp_a_d      = tail.xh;
        dp_b_d      = dp_y;
      end else if (accept) begin
        stage0_d.v  = 1'b1;
        stage0_d.it = '0;
        stage0_d.xh = in_xh;
        stage0_d.id = in_id;
        dp_a_d      = in_xh;
        dp_b_d      = in_y0;
      end else begin
        stage0_d.v  = 1'b0;
      end

      out_valid_d = retire;
      if (retire) begin
        out_y_d  = dp_y;
        out_id_d = tail.id;
      end

      // The tail record leaves the shadow line on every enabled edge.
      inflight_d = inflight_q + CNT_W'(stage0_d.v) - CNT_W'(tail.v);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage0_q    <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_id_q    <= '0;
      inflight_q  <= '0;
    end else begin
      stage0_q    <= stage0_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_id_q    <= out_id_d;
      inflight_q  <= inflight_d;
    end
  end

  assign dp_ce     = en;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;
  assign inflight  = inflight_q;
  assign busy      = (inflight_q != '0);

endmodule

// File: tb/tb_newton_iter_scheduler.sv
// Bench for newton_iter_scheduler: a default instance (ITERS=2) and an ITERS=1 instance,
// each closed around a behavioural datapath that applies y' = 3*y + xh after PIPE_LAT cycles.
module tb_newton_iter_scheduler;

  localparam int L     = 4;
  localparam int ITERS = 2;
  localparam int CW    = $clog2(L + 2);

  typedef struct {
    logic [3:0]  id;
    logic [31:0] y;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] xh;
    logic [31:0] y0;
    logic [3:0]  id;
    logic [31:0] exp2;
    logic [31:0] exp1;
  } vec_t;

  logic clk = 1'b0;
  logic rst, en, en1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Default instance signals
  logic          in_valid, in_ready, dp_ce, out_valid, busy;
  logic [31:0]   in_xh, in_y0, dp_a, dp_b, dp_y, out_y;
  logic [3:0]    in_id, out_id;
  logic [CW-1:0] inflight;
  // ITERS=1 instance signals
  logic          in_valid1, in_ready1, dp_ce1, out_valid1, busy1;
  logic [31:0]   in_xh1, in_y01, dp_a1, dp_b1, dp_y1, out_y1;
  logic [3:0]    in_id1, out_id1;
  logic [CW-1:0] inflight1;

  exp_t q[$];
  exp_t q1[$];
  vec_t vecs[8];

  logic        chk_dpb = 1'b0;
  logic [31:0] saved_y;
  int          max_if = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  newton_iter_scheduler #(.PIPE_LAT(L), .ITERS(ITERS), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_xh(in_xh), .in_y0(in_y0), .in_id(in_id), .dp_ce(dp_ce), .dp_a(dp_a), .dp_b(dp_b),
    .dp_y(dp_y), .out_valid(out_valid), .out_y(out_y), .out_id(out_id),
    .inflight(inflight), .busy(busy)
  );

  newton_iter_scheduler #(.PIPE_LAT(L), .ITERS(1), .ID_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_xh(in_xh1), .in_y0(in_y01), .in_id(in_id1), .dp_ce(dp_ce1), .dp_a(dp_a1),
    .dp_b(dp_b1), .dp_y(dp_y1), .out_valid(out_valid1), .out_y(out_y1), .out_id(out_id1),
    .inflight(inflight1), .busy(busy1)
  );

  function automatic logic [31:0] step(input logic [31:0] a, input logic [31:0] b);
    return b * 32'd3 + a;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] xh, input logic [31:0] y0,
                                        input int n);
    logic [31:0] y;
    y = y0;
    for (int i = 0; i < n; i++) y = step(xh, y);
    return y;
  endfunction

  // Behavioural datapaths: PIPE_LAT register stages, clock-enabled by dp_ce.
  logic [31:0] dpp  [L];
  logic [31:0] dpp1 [L];
  always @(posedge clk) begin
    if (dp_ce) begin
      dpp[0] <= step(dp_a, dp_b);
      for (int i = 1; i < L; i++) dpp[i] <= dpp[i-1];
    end
    if (dp_ce1) begin
      dpp1[0] <= step(dp_a1, dp_b1);
      for (int i = 1; i < L; i++) dpp1[i] <= dpp1[i-1];
    end
  end
  assign dp_y  = dpp[L-1];
  assign dp_y1 = dpp1[L-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Default instance: scoreboard pop, in_ready pattern, dp_b on recirculation, stalls.
  task automatic mon0();
    exp_t   e;
    int     d;
    logic   exp_rdy;
    if (chk_dpb) begin
      chk("dp_b_recirc", dp_b, saved_y);
      chk_dpb = 1'b0;
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: id %0d y %h, want no output", out_id, out_y);
      end else begin
        e = q.pop_front();
        chk("out_id", 32'(out_id), 32'(e.id));
        chk("out_y", out_y, e.y);
        chk("out_time", 32'(cyc), 32'(e.due));
      end
    end
    if (en) begin
      // A queued item recirculates when its tail pass is a whole pass before its last one.
      exp_rdy = 1'b1;
      foreach (q[i]) begin
        d = q[i].due - 1 - cyc;
        if (d >= L + 1 && d <= (ITERS - 1) * (L + 1) && d % (L + 1) == 0) exp_rdy = 1'b0;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (!in_ready) begin
        saved_y = dp_y;
        chk_dpb = 1'b1;
      end
      if (int'(inflight) > max_if) max_if = int'(inflight);
    end else begin
      chk("in_ready_en0", 32'(in_ready), 32'd0);
      foreach (q[i]) q[i].due++;
    end
  endtask

  task automatic mon1();
    exp_t e;
    if (out_valid1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out1: id %0d y %h, want no output", out_id1, out_y1);
      end else begin
        e = q1.pop_front();
        chk("out_id1", 32'(out_id1), 32'(e.id));
        chk("out_y1", out_y1, e.y);
        chk("out_time1", 32'(cyc), 32'(e.due));
      end
    end
    chk("in_ready1", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk_dpb = 1'b0;
      end else begin
        mon0();
        mon1();
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit sel, input logic [31:0] xh, input logic [31:0] y0,
                      input logic [3:0] id, input logic [31:0] ey);
    int   n;
    exp_t e;
    n = 0;
    if (!sel) begin
      in_valid = 1'b1; in_xh = xh; in_y0 = y0; in_id = id;
    end else begin
      in_valid1 = 1'b1; in_xh1 = xh; in_y01 = y0; in_id1 = id;
    end
    forever begin
      @(negedge clk);
      if (!sel ? in_ready : in_ready1) break;
      n++;
      if (n >= 60) break;
    end
    if (n >= 60) begin
      tests++; fails++;
      $display("FAIL send_timeout: id %0d not accepted, want accept", id);
    end else begin
      e.id  = id;
      e.y   = ey;
      e.due = cyc + 1 + (sel ? 1 : ITERS) * (L + 1);
      if (!sel) q.push_back(e);
      else      q1.push_back(e);
    end
    @(posedge clk); #1;
    if (!sel) in_valid = 1'b0;
    else      in_valid1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, want 0", q.size(), q1.size());
    end
    @(posedge clk); #1;
  endtask

  logic [CW-1:0] s_inf;
  logic [31:0]   s_a, s_b, s_y;
  logic [3:0]    s_id;
  int            start;

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].xh   = 32'h3F00_0000 + 32'(i) * 32'h0010_0000;
      vecs[i].y0   = 32'h3F80_0000 - 32'(i) * 32'h0003_1000;
      vecs[i].id   = 4'(i);
      vecs[i].exp2 = model(vecs[i].xh, vecs[i].y0, ITERS);
      vecs[i].exp1 = model(vecs[i].xh, vecs[i].y0, 1);
    end
    rst = 1'b0; en = 1'b1; en1 = 1'b1;
    in_valid = 1'b0; in_xh = '0; in_y0 = '0; in_id = '0;
    in_valid1 = 1'b0; in_xh1 = '0; in_y01 = '0; in_id1 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dp_a", dp_a, 32'd0);
    chk("rst_dp_b", dp_b, 32'd0);
    chk("rst_dp_ce", 32'(dp_ce), 32'd1);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    rst = 1'b1;

    // Single operand, x = 1.0
    send(1'b0, 32'h3F00_0000, 32'h3F80_0000, 4'd3, model(32'h3F00_0000, 32'h3F80_0000, ITERS));
    wait_idle();

    // Back-to-back burst of 8, ids 0..7
    for (int i = 0; i < 8; i++) send(1'b0, vecs[i].xh, vecs[i].y0, vecs[i].id, vecs[i].exp2);
    wait_idle();

    // ITERS=1: one accept per cycle
    start = cyc;
    for (int i = 0; i < 8; i++) send(1'b1, vecs[i].xh, vecs[i].y0, vecs[i].id, vecs[i].exp1);
    chk("iters1_throughput", 32'(cyc - start), 32'd8);
    wait_idle();

    // Enable held low for 3 cycles mid-flight
    send(1'b0, vecs[5].xh, vecs[5].y0, 4'd9, vecs[5].exp2);
    send(1'b0, vecs[6].xh, vecs[6].y0, 4'd10, vecs[6].exp2);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    s_inf = inflight; s_a = dp_a; s_b = dp_b; s_y = out_y; s_id = out_id;
    repeat (3) begin
      @(posedge clk); #1;
      chk("frz_inflight", 32'(inflight), 32'(s_inf));
      chk("frz_dp_a", dp_a, s_a);
      chk("frz_dp_b", dp_b, s_b);
      chk("frz_out_y", out_y, s_y);
      chk("frz_out_id", 32'(out_id), 32'(s_id));
      chk("frz_out_valid", 32'(out_valid), 32'd0);
      chk("frz_dp_ce", 32'(dp_ce), 32'd0);
    end
    en = 1'b1;
    wait_idle();

    // Reset with 4 items in flight, then a fresh operand
    for (int i = 0; i < 4; i++) send(1'b0, vecs[i].xh, vecs[i].y0, 4'(8 + i), vecs[i].exp2);
    @(posedge clk); #1;
    chk("pre_rst_inflight", 32'(inflight), 32'd4);
    rst = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_y", out_y, 32'd0);
    chk("mid_rst_out_id", 32'(out_id), 32'd0);
    chk("mid_rst_inflight", 32'(inflight), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dp_a", dp_a, 32'd0);
    chk("mid_rst_dp_b", dp_b, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    send(1'b0, vecs[7].xh, vecs[7].y0, 4'd12, vecs[7].exp2);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;

    chk("max_inflight_le5", 32'(max_if <= L + 1), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
